fifo_64_rd_stream: RTL

FIFO_64_RD_STREAM -- requirements
Module: fifo_64_rd_stream

---
 rtl/fifo_64_rd_stream_pkg.sv | 14 +
 rtl/fifo_64_rd_stream_if.sv | 25 ++
 rtl/fifo_64_rd_stream_buf.sv | 48 ++++
 rtl/fifo_64_rd_stream.sv | 85 ++++++++
 4 files changed

// File: rtl/fifo_64_rd_stream_pkg.sv
// rtl/fifo_64_rd_stream_pkg.sv - shared constants and pointer helper for fifo_64_rd_stream
package fifo_64_rd_stream_pkg;

    localparam int BUF_DEPTH     = 3;
    localparam int PTR_W         = 2;
    localparam int OCC_W         = 2;
    localparam int DEFAULT_WIDTH = 64;

    // Advance a buffer pointer, wrapping after the last of the three slots
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_64_rd_stream_if.sv
// rtl/fifo_64_rd_stream_if.sv - upstream FIFO read port and output stream bundle
interface fifo_64_rd_stream_if
    import fifo_64_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output fifo_rd_en, m_data, m_valid, m_last,
        input  fifo_dout, fifo_empty, fifo_valid, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_last,
        output fifo_dout, fifo_empty, fifo_valid, m_ready
    );
endinterface

// File: rtl/fifo_64_rd_stream_buf.sv
// rtl/fifo_64_rd_stream_buf.sv - three-entry in-order skid buffer between FIFO read data and stream
module fifo_64_rd_stream_buf
    import fifo_64_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [OCC_W-1:0] o_occ
);
    logic [WIDTH-1:0] r_mem [0:BUF_DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Storage and pointers; caller guarantees push only when a slot is free (or a pop frees one)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_64_rd_stream.sv
// rtl/fifo_64_rd_stream.sv - non-showahead FIFO reader to packetised stream; FIFO_64_RD_STREAM_STALL_CNT_EN enables stall counter
module fifo_64_rd_stream
    import fifo_64_rd_stream_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PKT_LEN = 8,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_64_rd_stream_if.master  bus,
    output logic                 err_ovf,
    output logic [CNT_W-1:0]     stall_cnt
);
    logic [OCC_W-1:0] w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_rd_en;
    logic             r_inflight;
    logic [15:0]      r_beat;
    logic             r_err_ovf;

    assign w_valid = (w_occ != '0);
    assign w_full  = (w_occ == OCC_W'(BUF_DEPTH));
    assign w_pop   = w_valid & bus.m_ready;
    // A word arriving into a full buffer is dropped unless the head leaves on the same edge
    assign w_push  = bus.fifo_valid & (~w_full | w_pop);
    // Read credit counts words held plus the one possibly in flight; no dependence on m_ready
    assign w_rd_en = rst_n & ~bus.fifo_empty
                   & (({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(BUF_DEPTH));

    fifo_64_rd_stream_buf #(.WIDTH(WIDTH)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_data (bus.fifo_dout),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_head;
    assign bus.m_last     = w_valid & (r_beat == 16'(PKT_LEN - 1));
    assign err_ovf        = r_err_ovf;

    // Track whether a read was accepted last cycle, beat position in packet, and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_beat <= (r_beat == 16'(PKT_LEN - 1)) ? '0 : r_beat + 1'b1;
            end
            if (bus.fifo_valid && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

`ifdef FIFO_64_RD_STREAM_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where a beat is offered but not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !bus.m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
